// File: rtl/activation_scheduler.sv
// activation_scheduler: job-level sequencer for the activation datapath.
// A start pulse in IDLE latches the job. The scheduler then streams rows from
// the accumulator buffer, enables the activation unit one cycle later, and
// writes each result to the output buffer two cycles after its read. A single
// advance term stalls the whole pipeline whenever a write is held by
// wr_ready_i == 0.
//
// Ports:
//   clk_i, async_rst_ni (async, active-low), sync_rst_i (sync, active-high)
//   start_i, cfg_sel_i, cfg_rows_i, cfg_src_base_i, cfg_dst_base_i  job setup
//   rd_en_o, rd_addr_o      accumulator-buffer read port
//   act_en_o, act_sel_o     activation-unit control
//   wr_en_o, wr_addr_o      output-buffer write port; wr_ready_i is backpressure
//   busy_o, done_o          job status
//   stall_cycles_o          backpressure stall counter, present only when
//                           ACT_SCHED_PERF_CNT_EN is defined
// rd_en_o, act_en_o and wr_en_o are same-cycle decodes of the registered
// pipeline state and wr_ready_i. This gives one-cycle spacing between the
// stages and a throughput of one row per cycle.
module activation_scheduler #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic                  clk_i,
  input  logic                  async_rst_ni,
  input  logic                  sync_rst_i,
  input  logic                  start_i,
  input  logic [1:0]            cfg_sel_i,
  input  logic [CNT_WIDTH-1:0]  cfg_rows_i,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base_i,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  act_en_o,
  output logic [1:0]            act_sel_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  input  logic                  wr_ready_i,
  output logic                  busy_o,
  output logic                  done_o
`ifdef ACT_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rows_q, rows_d;
  logic [CNT_WIDTH-1:0]  issue_q, issue_d;
  logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [1:0]            sel_q, sel_d;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic                  adv;
`ifdef ACT_SCHED_PERF_CNT_EN
  logic [31:0]           stall_q, stall_d;
`endif

  // State register
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state_q  <= S_IDLE;
      rows_q   <= '0;
      issue_q  <= '0;
      wr_cnt_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      sel_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
`ifdef ACT_SCHED_PERF_CNT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      issue_q  <= issue_d;
      wr_cnt_q <= wr_cnt_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      sel_q    <= sel_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
`ifdef ACT_SCHED_PERF_CNT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    issue_d  = issue_q;
    wr_cnt_d = wr_cnt_q;
    src_d    = src_q;
    dst_d    = dst_q;
    sel_d    = sel_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
`ifdef ACT_SCHED_PERF_CNT_EN
    stall_d  = stall_q;
`endif
    rd_en_o  = 1'b0;
    // A held write in stage 2 freezes every stage behind it.
    adv      = !v2_q || wr_ready_i;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rows_d   = cfg_rows_i;
          src_d    = cfg_src_base_i;
          dst_d    = cfg_dst_base_i;
          sel_d    = cfg_sel_i;
          issue_d  = '0;
          wr_cnt_d = '0;
`ifdef ACT_SCHED_PERF_CNT_EN
          stall_d  = '0;
`endif
          state_d  = (cfg_rows_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (adv && (issue_q < rows_q)) begin
          rd_en_o = 1'b1;
          issue_d = issue_q + CNT_WIDTH'(1);
          if (issue_d == rows_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    act_en_o = v1_q && adv;
    wr_en_o  = v2_q && wr_ready_i;
    if (adv) begin
      v1_d = rd_en_o;
      v2_d = v1_q;
    end
    if (wr_en_o) begin
      wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
      if ((state_q == S_DRAIN) && (wr_cnt_d == rows_q)) state_d = S_DONE;
    end

`ifdef ACT_SCHED_PERF_CNT_EN
    // Saturating count of cycles lost to output-buffer backpressure.
    if (((state_q == S_RUN) || (state_q == S_DRAIN)) && v2_q && !wr_ready_i
        && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
`endif

    if (sync_rst_i) begin
      state_d  = S_IDLE;
      rows_d   = '0;
      issue_d  = '0;
      wr_cnt_d = '0;
      src_d    = '0;
      dst_d    = '0;
      sel_d    = '0;
      v1_d     = 1'b0;
      v2_d     = 1'b0;
`ifdef ACT_SCHED_PERF_CNT_EN
      stall_d  = '0;
`endif
    end
  end

  // Addresses wrap modulo the buffer depth.
  assign rd_addr_o = src_q + ADDR_WIDTH'(issue_q);
  assign wr_addr_o = dst_q + ADDR_WIDTH'(wr_cnt_q);
  assign act_sel_o = sel_q;
  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
`ifdef ACT_SCHED_PERF_CNT_EN
  assign stall_cycles_o = stall_q;
`endif

endmodule

// File: doc/activation_scheduler.md
Name: activation_scheduler

Overview:
Job-level controller that sequences the activation unit. On `start` it:
- streams `cfg_rows` row vectors out of the accumulator buffer,
- drives the activation unit's `en` and `sel`,
- writes each activated row into the output buffer at a destination address.

It tracks the 2-cycle read+activate pipeline, honours output-buffer backpressure by stalling the whole pipeline, and signals completion with a `done` pulse.

Parameters:
- ADDR_WIDTH, 8, width of the accumulator-buffer and output-buffer row addresses.
- CNT_WIDTH, 9, width of the row counters; must be ≥ ADDR_WIDTH+1 so a full buffer (2^ADDR_WIDTH rows) is representable.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- async_rst  in  1  asynchronous reset, active-low.
- sync_rst  in  1  synchronous reset, active-high; same effect as async_rst on the next edge.
- start  in  1  one-cycle job launch pulse; sampled only in IDLE.
- cfg_sel  in  2  activation select latched at start (0 ReLU, 1 Sigmoid, 2 Tanh, 3 bypass).
- cfg_rows  in  CNT_WIDTH  number of rows in the job, latched at start.
- cfg_src_base  in  ADDR_WIDTH  first accumulator-buffer row, latched at start.
- cfg_dst_base  in  ADDR_WIDTH  first output-buffer row, latched at start.
- rd_en  out  1  accumulator-buffer read strobe; data appears on the buffer output 1 cycle later.
- rd_addr  out  ADDR_WIDTH  accumulator-buffer read address.
- act_en  out  1  activation-unit enable; the unit registers its result on this edge.
- act_sel  out  2  activation-unit select, equal to the latched cfg_sel.
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  ADDR_WIDTH  output-buffer write address.
- wr_ready  in  1  output buffer can accept a write this cycle.
- busy  out  1  high from the cycle after an accepted start until the done cycle inclusive.
- done  out  1  one-cycle pulse when the last row has been written.

Behaviour:
- Reset (async or sync), all outputs 0:
  - rd_en, act_en, wr_en, busy, done = 0.
  - rd_addr, wr_addr, act_sel = 0.
  - Internal counters and valid bits = 0; FSM = IDLE.
- Reset mid-job aborts the job immediately. No further rd_en or wr_en is issued; no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start, latch all cfg_* inputs, clear issue_cnt and wr_cnt.
  - If cfg_rows == 0, go to DONE; otherwise go to RUN.
  - start is ignored outside IDLE.
- Pipeline advance: `adv = !v2 || wr_ready`, where v1 and v2 are the stage valid bits.
- Stage 0, RUN state:
  - When `adv && issue_cnt < rows`: rd_en = 1, rd_addr = src_base + issue_cnt, issue_cnt++.
  - When the last row is issued, go to DRAIN.
- Stage 1: when adv, `v1 <= rd_en`.
  - act_en = v1 && adv.
- Stage 2: when adv, `v2 <= v1`.
  - wr_en = v2 && wr_ready.
  - wr_addr = dst_base + wr_cnt; wr_cnt++ on each write.
- Stall (adv = 0):
  - rd_en = 0 and act_en = 0; v1, v2 and all counters hold.
  - The accumulator buffer holds its read data while rd_en is low (interface requirement on that buffer).
  - The activation unit holds its output while en is low.
- Latency and throughput:
  - A rd_en in cycle t gives act_en in t+1 and wr_en in t+2 when unstalled.
  - Sustained throughput is 1 row/cycle.
- DRAIN: when wr_cnt reaches rows (last write accepted), go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 1, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH: base + count wraps past the top row with no error.
- act_sel is constant for the whole job. Changing cfg_* while busy has no effect.
- Persistent wr_ready = 0 stalls indefinitely. No timeout.

Optional Feature:
- Macro: ACT_SCHED_PERF_CNT_EN.
- When defined:
  - Output port `stall_cycles` [31:0] counts cycles in RUN or DRAIN with `v2 && !wr_ready`.
  - The counter saturates at 0xFFFFFFFF, clears on reset and on each accepted start, and holds its value after done.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- cfg_rows=4, src=0x10, dst=0x80, sel=1, wr_ready=1 → rd_addr 0x10..0x13 on 4 consecutive cycles; act_en lagging rd_en by 1 cycle with act_sel=1; wr_addr 0x80..0x83 lagging by 2 cycles; done 1 cycle after the last write; busy for 7 cycles.
- cfg_rows=3, wr_ready low for 3 cycles when the first write is pending → rd_en and act_en held 0 during the stall; wr_addr 0x80 issued once after release; exactly 3 writes total; stall_cycles=3 with the macro defined.
- cfg_rows=0 + start → no rd_en or wr_en; done pulses 1 cycle after start; back to IDLE.
- src=0xFE, dst=0xFF, cfg_rows=3 → rd_addr 0xFE, 0xFF, 0x00; wr_addr 0xFF, 0x00, 0x01.
- Second start while busy, then async_rst low mid-job → second start ignored; on reset all outputs 0 immediately; no done pulse; next start runs a clean job.
- sync_rst=1 for 1 cycle during DRAIN → next edge gives IDLE with outputs 0; remaining rows are not written.
